// File: rtl/bird_pkg.sv
// ============================================================================
// Module   : bird_pkg
// Brief    : Shared types and constants for the bird_judge game logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bird_pkg;

    // Game flow states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        LOST = 2'd2
    } state_t;

    // Fibonacci LFSR taps 8,6,5,4 expressed as a mask over bits [7:0]
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // One BCD digit
    typedef logic [3:0] bcd_t;

endpackage

`default_nettype wire

// File: rtl/bird_judge_pipe_gen.sv
// ============================================================================
// Module   : pipe_gen
// Brief    : Produces the next column entering the pipe field: a wall with a
//            pseudo-random gap every PIPE_SPACING ticks, empty otherwise.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_gen
    import bird_pkg::*;
#(
    parameter int         PIPE_SPACING = 4,
    parameter int         GAP          = 3,
    parameter logic [7:0] SEED         = 8'h01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_en,
    input  logic       clear,
    output logic [7:0] new_col
);

    localparam int               SPC_W    = $clog2(PIPE_SPACING);
    localparam logic [SPC_W-1:0] SPC_LAST = SPC_W'(PIPE_SPACING - 1);
    // An all-zero LFSR would lock up, so a zero seed is replaced
    localparam logic [7:0]       SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0]       GAP_ONES = 8'((1 << GAP) - 1);
    localparam logic [2:0]       MAX_BASE = 3'(8 - GAP);

    logic [7:0]       lfsr;
    logic [SPC_W-1:0] spc;
    logic [2:0]       gap_base;
    logic [7:0]       gap_mask;

    // Gap placement from the current (not yet advanced) LFSR value
    always_comb begin
        gap_base = (lfsr[2:0] > MAX_BASE) ? MAX_BASE : lfsr[2:0];
        gap_mask = GAP_ONES << gap_base;
        new_col  = (spc == '0) ? ~gap_mask : 8'h00;
    end

    // LFSR and spacing counter; clear restarts spacing but keeps randomness
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= SEED_EFF;
            spc  <= '0;
        end else if (clear) begin
            spc  <= '0;
        end else if (tick_en) begin
            spc  <= (spc == SPC_LAST) ? '0 : spc + 1'b1;
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
        end
    end

endmodule

`default_nettype wire

// File: rtl/bird_judge.sv
// ============================================================================
// Module   : bird_judge
// Brief    : Game judge for the bird column: scrolls pipes, detects bird/pipe
//            collisions, keeps a saturating BCD score and paces gravity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bird_judge
    import bird_pkg::*;
#(
    parameter int         COLS         = 8,
    parameter int         BIRD_COL     = 0,
    parameter int         PIPE_SPACING = 4,
    parameter int         GAP          = 3,
    parameter int         GRAV_DIV     = 2,
    parameter logic [7:0] SEED         = 8'h01
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              tick,
    input  logic [7:0]        position,
    output logic              lose,
    output logic              gravity,
    output logic [8*COLS-1:0] pipes,
    output logic [3:0]        score_tens,
    output logic [3:0]        score_ones
);

    localparam int               DIV_W    = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(GRAV_DIV - 1);

    state_t           state;
    state_t           next_state;
    logic             start_q;
    logic             start_rise;
    logic             hit;
    logic             tick_play;
    logic             clear;
    logic [7:0]       bird_col;
    logic [7:0]       new_col;
    logic [DIV_W-1:0] div;
    bcd_t             tens;
    bcd_t             ones;

    assign score_tens = tens;
    assign score_ones = ones;

    // A hit pre-empts any tick in the same cycle
    always_comb begin
        start_rise = start & ~start_q;
        bird_col   = pipes[8*BIRD_COL +: 8];
        hit        = (state == PLAY) && (|(bird_col & position));
        tick_play  = (state == PLAY) && tick && !hit;
    end

    // Next-state logic; entering PLAY requests a clear of the game state
    always_comb begin
        next_state = state;
        clear      = 1'b0;
        case (state)
            IDLE: if (start_rise) begin
                next_state = PLAY;
                clear      = 1'b1;
            end
            PLAY: if (hit) next_state = LOST;
            LOST: if (start_rise) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register, start edge history and registered flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            start_q <= 1'b0;
            lose    <= 1'b0;
            gravity <= 1'b0;
        end else begin
            state   <= next_state;
            start_q <= start;
            lose    <= (next_state == LOST);
            gravity <= tick_play && (div == '0);
        end
    end

    // Pipe field: shift toward column 0, new column enters at the right
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipes <= '0;
        end else if (clear) begin
            pipes <= '0;
        end else if (tick_play) begin
            pipes <= {new_col, pipes[8*COLS-1:8]};
        end
    end

    // Score counts ticks where a wall is passing the bird; gravity divider
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens <= '0;
            ones <= '0;
            div  <= '0;
        end else if (clear) begin
            tens <= '0;
            ones <= '0;
            div  <= '0;
        end else if (tick_play) begin
            div <= (div == DIV_LAST) ? '0 : div + 1'b1;
            if ((bird_col != 8'h00) && !((tens == 4'd9) && (ones == 4'd9))) begin
                if (ones == 4'd9) begin
                    ones <= 4'd0;
                    tens <= tens + 4'd1;
                end else begin
                    ones <= ones + 4'd1;
                end
            end
        end
    end

    pipe_gen #(
        .PIPE_SPACING (PIPE_SPACING),
        .GAP          (GAP),
        .SEED         (SEED)
    ) u_pipe_gen (
        .clk     (clk),
        .reset   (reset),
        .tick_en (tick_play),
        .clear   (clear),
        .new_col (new_col)
    );

endmodule

`default_nettype wire
